// File: rtl/aes_pkg.sv
// Shared AES-128 types and byte/word helpers for the encryptor and key schedule.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } aes_state_e;

  localparam int NR = 10;

  // Round constant in the upper key-schedule byte; rounds outside 1..10 never use it.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return gm2(b) ^ b;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm2(a0) ^ gm3(a1) ^ a2 ^ a3,
            a0 ^ gm2(a1) ^ gm3(a2) ^ a3,
            a0 ^ a1 ^ gm2(a2) ^ gm3(a3),
            gm3(a0) ^ a1 ^ a2 ^ gm2(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]),  mix_column(s[31:0])};
  endfunction

  // Byte (row r, column c) sits at index 4*c+r counting from the MSB.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[127-8*(4*c+rr) -: 8] = s[127-8*(4*((c+rr)%4)+rr) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One combinational AES-128 key-expansion round with its own four S-boxes.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon_byte,
  output logic [127:0] rk_next
);

  logic [31:0] w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk;
  assign rot = rot_word(w3);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .sbox_in  (rot[8*b +: 8]),
      .sbox_out (sub[8*b +: 8])
    );
  end

  assign t  = sub ^ {rcon_byte, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse by x^254 followed by the affine transform.
module aes_sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv;

  // Addition chain to x^254; zero maps to zero as the S-box requires.
  always_comb begin
    x2   = gf_mul(sbox_in, sbox_in);
    x3   = gf_mul(x2, sbox_in);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(x240, x14);
    sbox_out = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_enc128_lanes.sv
// Iterative AES-128 ECB encryptor; NUM_LANES words go through SubBytes per SUB cycle.
//  state | meaning
//  IDLE  | waiting for a plaintext block, in_ready high
//  SUB   | SubBytes on NUM_LANES words per cycle; round key advanced on the first cycle
//  MIX   | ShiftRows/MixColumns/AddRoundKey, or final round into out_block
//  DONE  | ciphertext held on out_block until out_ready
module aes_enc128_lanes
  import aes_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4) begin : g_bad_lanes
    $error("aes_enc128_lanes: NUM_LANES must be 1, 2 or 4");
  end

  localparam int SUB_CYCLES = 4 / NUM_LANES;
  localparam logic [1:0] SUB_LAST = 2'(SUB_CYCLES - 1);

  aes_state_e   state;
  logic [127:0] key_reg, rk_reg, block_reg, rk_next, sub_block, k0;
  logic [3:0]   rnd;
  logic [1:0]   sub_ctr;
  logic [7:0]   rcon_cur;
  logic [31:0]  blk_w  [4];
  logic [31:0]  sub_w  [4];
  logic [31:0]  lane_in  [NUM_LANES];
  logic [31:0]  lane_out [NUM_LANES];

  function automatic logic [1:0] lane_idx(input logic [1:0] ctr, input int lane);
    return 2'(int'(ctr) * NUM_LANES + lane);
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  // A key strobed in the accept cycle applies to that very block.
  assign k0       = key_load ? key_in : key_reg;
  assign rcon_cur = rcon(rnd);

  for (genvar i = 0; i < 4; i++) begin : g_words
    assign blk_w[i] = block_reg[127-32*i -: 32];
  end

  always_comb begin
    for (int j = 0; j < NUM_LANES; j++) lane_in[j] = blk_w[lane_idx(sub_ctr, j)];
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    for (genvar b = 0; b < 4; b++) begin : g_byte
      aes_sbox u_sbox (
        .sbox_in  (lane_in[j][8*b +: 8]),
        .sbox_out (lane_out[j][8*b +: 8])
      );
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) sub_w[i] = blk_w[i];
    for (int j = 0; j < NUM_LANES; j++) sub_w[lane_idx(sub_ctr, j)] = lane_out[j];
  end
  assign sub_block = {sub_w[0], sub_w[1], sub_w[2], sub_w[3]};

  aes_key_step u_key_step (
    .rk        (rk_reg),
    .rcon_byte (rcon_cur),
    .rk_next   (rk_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_reg   <= '0;
      rk_reg    <= '0;
      block_reg <= '0;
      rnd       <= '0;
      sub_ctr   <= '0;
      out_valid <= 1'b0;
      out_block <= '0;
    end else begin
      if (key_load) key_reg <= key_in;
      case (state)
        IDLE: begin
          if (in_valid) begin
            block_reg <= in_block ^ k0;
            rk_reg    <= k0;
            rnd       <= 4'd1;
            sub_ctr   <= '0;
            state     <= SUB;
          end
        end
        SUB: begin
          block_reg <= sub_block;
          if (sub_ctr == 2'd0) rk_reg <= rk_next;
          if (sub_ctr == SUB_LAST) begin
            sub_ctr <= '0;
            state   <= MIX;
          end else begin
            sub_ctr <= sub_ctr + 2'd1;
          end
        end
        MIX: begin
          if (rnd < 4'(NR)) begin
            block_reg <= mix_columns(shift_rows(block_reg)) ^ rk_reg;
            rnd       <= rnd + 4'd1;
            state     <= SUB;
          end else begin
            out_block <= shift_rows(block_reg) ^ rk_reg;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc128_lanes.sv
// Bench for aes_enc128_lanes: instances with 4, 2 and 1 lanes against a byte-level AES model.
module tb_aes_enc128_lanes;

  localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] in_block = '0;
  logic [2:0]   in_valid = '0;
  logic [2:0]   out_ready = '0;
  logic [2:0]   in_ready, out_valid, busy;
  logic [127:0] out_block [3];

  int n_pass = 0;
  int n_total = 0;
  int exp_lat [3] = '{20, 30, 50};
  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  aes_enc128_lanes #(.NUM_LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_block(in_block),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_block(out_block[0]),
    .busy(busy[0]));

  aes_enc128_lanes #(.NUM_LANES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_block(in_block),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_block(out_block[1]),
    .busy(busy[1]));

  aes_enc128_lanes #(.NUM_LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_block(in_block),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_block(out_block[2]),
    .busy(busy[2]));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box table from the generator 3 and its inverse walk through GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] tb, rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ w[i];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int k = 0; k < 4; k++) tmp[k] = w[4*(i-1)+k];
      if (i % 4 == 0) begin
        tb = tmp[0];
        for (int k = 0; k < 3; k++) tmp[k] = tmp[k+1];
        tmp[3] = tb;
        for (int k = 0; k < 4; k++) tmp[k] = sbox_t[tmp[k]];
        tmp[0] = tmp[0] ^ rc;
        rc = xt(rc);
      end
      for (int k = 0; k < 4; k++) w[4*i+k] = w[4*(i-4)+k] ^ tmp[k];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Returns at the falling edge right after the accepting rising edge.
  task automatic start_block(input int idx, input bit ld, input logic [127:0] key,
                             input logic [127:0] pt);
    int waited;
    waited = 0;
    @(negedge clk);
    key_in = key;
    key_load = ld;
    in_block = pt;
    in_valid[idx] = 1'b1;
    while (!in_ready[idx] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check("accept_timeout", 128'd0, 128'd1);
    @(negedge clk);
    key_load = 1'b0;
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_out(input int idx, output int lat);
    lat = 0;
    while (!out_valid[idx] && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid[idx]) check("out_valid_timeout", 128'd0, 128'd1);
  endtask

  task automatic drain(input int idx);
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
  endtask

  typedef struct {
    int           idx;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int lat;
    bit ok;
    logic [127:0] ob, rk, rp;

    build_sbox();
    vecs[0] = '{0, KB,  PT_B,  CT_B,  20};
    vecs[1] = '{0, KC1, PT_C1, CT_C1, 20};
    vecs[2] = '{1, KC1, PT_C1, CT_C1, 30};
    vecs[3] = '{2, KC1, PT_C1, CT_C1, 50};

    repeat (3) @(negedge clk);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_out_block", out_block[0], 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 128'(in_ready), 128'd7);

    foreach (vecs[v]) begin
      start_block(vecs[v].idx, 1'b1, vecs[v].key, vecs[v].pt);
      wait_out(vecs[v].idx, lat);
      check($sformatf("vec%0d_ct", v), out_block[vecs[v].idx], vecs[v].ct);
      check($sformatf("vec%0d_latency", v), 128'(lat), 128'(vecs[v].lat));
      drain(vecs[v].idx);
      check($sformatf("vec%0d_idle", v), 128'({in_ready[vecs[v].idx], out_valid[vecs[v].idx]}), 128'b10);
    end

    // Backpressure: result held 15 cycles while a new block waits.
    start_block(0, 1'b1, KC1, PT_C1);
    wait_out(0, lat);
    ob = out_block[0];
    check("bp_first_ct", ob, CT_C1);
    in_block = PT_B;
    in_valid[0] = 1'b1;
    ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (out_block[0] !== ob || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) ok = 1'b0;
    end
    check("bp_hold_stable", 128'(ok), 128'd1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_released", 128'({out_valid[0], in_ready[0], out_block[0] == ob}), 128'b011);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("bp_next_accepted", 128'({busy[0], in_ready[0]}), 128'b10);
    wait_out(0, lat);
    check("bp_next_latency", 128'(lat), 128'd20);
    check("bp_next_ct", out_block[0], ref_enc(KC1, PT_B));
    drain(0);

    // Key change during round 5 leaves the running block alone.
    start_block(0, 1'b1, KC1, PT_C1);
    repeat (9) @(negedge clk);
    key_in = KB;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    wait_out(0, lat);
    check("midflight_ct", out_block[0], CT_C1);
    drain(0);
    start_block(0, 1'b0, KC1, PT_B);
    wait_out(0, lat);
    check("new_key_ct", out_block[0], CT_B);
    drain(0);

    // key_reg holds the B key; the accept-cycle strobe must win.
    start_block(0, 1'b1, KC1, PT_C1);
    wait_out(0, lat);
    check("bypass_ct", out_block[0], CT_C1);
    drain(0);

    // Reset during round 3.
    start_block(0, 1'b1, KB, PT_B);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cleared", 128'({busy[0], out_valid[0]}), 128'd0);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) ok = 1'b0;
    end
    check("abort_no_out_valid", 128'(ok), 128'd1);
    check("abort_in_ready", 128'(in_ready[0]), 128'd1);
    start_block(0, 1'b1, KB, PT_B);
    wait_out(0, lat);
    check("after_abort_ct", out_block[0], CT_B);
    check("after_abort_latency", 128'(lat), 128'd20);
    drain(0);

    // Random keys and plaintexts across all lane counts.
    for (int i = 0; i < 9; i++) begin
      int idx;
      idx = i % 3;
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      if (i % 2 == 1) begin
        @(negedge clk);
        key_in = rk;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        start_block(idx, 1'b0, ~rk, rp);
      end else begin
        start_block(idx, 1'b1, rk, rp);
      end
      wait_out(idx, lat);
      check($sformatf("rand%0d_ct", i), out_block[idx], ref_enc(rk, rp));
      check($sformatf("rand%0d_latency", i), 128'(lat), 128'(exp_lat[idx]));
      drain(idx);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
